// File: rtl/game_pkg.sv
// Shared game controller definitions: state encoding (one-hot, doubles as the status output) and key codes.
package game_pkg;

   localparam logic [3:0] STATUS_IDLE  = 4'b0001;
   localparam logic [3:0] STATUS_PAUSE = 4'b0010;
   localparam logic [3:0] STATUS_PLAY  = 4'b0100;
   localparam logic [3:0] STATUS_OVER  = 4'b1000;

   localparam logic [7:0] START_KEY = 8'h2C;
   localparam logic [7:0] PAUSE_KEY = 8'h13;

   typedef enum logic [3:0] {
      S_IDLE  = STATUS_IDLE,
      S_PAUSE = STATUS_PAUSE,
      S_PLAY  = STATUS_PLAY,
      S_OVER  = STATUS_OVER
   } state_e;

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD counter with synchronous clear and increment, saturating at all nines.
module bcd_counter #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   input  logic                  inc_i,
   output logic [4*DIGITS-1:0]   count_o
);

   localparam int unsigned W = 4 * DIGITS;

   logic [W-1:0] count_q, count_d;
   logic         all_nines;
   logic         carry;

   // Ripple the increment through the digits; hold once every digit reads 9.
   always_comb begin
      count_d   = count_q;
      all_nines = 1'b1;
      carry     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (count_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
      end
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && !all_nines) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
               if (count_q[4*i +: 4] == 4'd9) begin
                  count_d[4*i +: 4] = 4'd0;
               end else begin
                  count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                  carry             = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/game_ctrl.sv
// Runner-game controller: frame sync, key edge detect, lives/score/speed/invulnerability.
// Define GAME_CTRL_PAUSE_EN to enable the PAUSE state toggled by PAUSE_KEY.
module game_ctrl
   import game_pkg::*;
#(
   parameter int unsigned LIVES          = 3,
   parameter int unsigned SCORE_DIGITS   = 4,
   parameter int unsigned N_OBST         = 2,
   parameter int unsigned INVULN_FRAMES  = 60,
   parameter int unsigned SPEEDUP_FRAMES = 600,
   parameter int unsigned MAX_SPEED      = 7,
   parameter int unsigned FALL_MARGIN    = 8
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      frame_clk,
   input  logic [7:0]                keycode,
   input  logic [9:0]                StickmanBottom,
   input  logic [9:0]                GroundY,
   input  logic [N_OBST-1:0]         hit,
   output logic [3:0]                status,
   output logic [4*SCORE_DIGITS-1:0] score,
   output logic [4*SCORE_DIGITS-1:0] hiscore,
   output logic [3:0]                lives,
   output logic [3:0]                speed,
   output logic                      invuln,
   output logic                      frame_tick
);

   localparam int unsigned SW    = 4 * SCORE_DIGITS;
   localparam int unsigned INV_W = 8;
   localparam int unsigned SPD_W = 12;

   state_e           state_q, state_d;
   logic             fs1_q, fs2_q, fs_prev_q, frame_tick_q;
   logic [7:0]       key_prev_q;
   logic [3:0]       lives_q, lives_d;
   logic [3:0]       speed_q, speed_d;
   logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
   logic [SPD_W-1:0] spd_cnt_q, spd_cnt_d;
   logic [SW-1:0]    hiscore_q, hiscore_d;
   logic             invuln_q;
   logic [SW-1:0]    score_cnt;
   logic             score_clr, score_inc;
   logic             start_ev, fall;

   assign start_ev = (keycode == START_KEY) && (key_prev_q != START_KEY);
   assign fall     = {1'b0, StickmanBottom} > (11'(GroundY) + 11'(FALL_MARGIN));

`ifdef GAME_CTRL_PAUSE_EN
   logic pause_ev;
   assign pause_ev = (keycode == PAUSE_KEY) && (key_prev_q != PAUSE_KEY);
`endif

   bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score (
      .clk     (Clk),
      .rst_n   (Reset_n),
      .clr_i   (score_clr),
      .inc_i   (score_inc),
      .count_o (score_cnt)
   );

   // Game state and per-frame bookkeeping; fall beats hit, OVER beats pause.
   always_comb begin
      state_d   = state_q;
      lives_d   = lives_q;
      speed_d   = speed_q;
      inv_cnt_d = inv_cnt_q;
      spd_cnt_d = spd_cnt_q;
      hiscore_d = hiscore_q;
      score_clr = 1'b0;
      score_inc = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_ev) begin
               state_d   = S_PLAY;
               score_clr = 1'b1;
               lives_d   = 4'(LIVES);
               speed_d   = 4'd1;
               inv_cnt_d = '0;
               spd_cnt_d = '0;
            end
         end
         S_PLAY: begin
            if (frame_tick_q) begin
               score_inc = 1'b1;
               if (inv_cnt_q != '0) inv_cnt_d = inv_cnt_q - INV_W'(1);
               if (spd_cnt_q == SPD_W'(SPEEDUP_FRAMES - 1)) begin
                  spd_cnt_d = '0;
                  if (speed_q < 4'(MAX_SPEED)) speed_d = speed_q + 4'd1;
               end else begin
                  spd_cnt_d = spd_cnt_q + SPD_W'(1);
               end
            end
            if (frame_tick_q && fall) begin
               lives_d = 4'd0;
               state_d = S_OVER;
            end else if ((|hit) && (inv_cnt_q == '0)) begin
               inv_cnt_d = INV_W'(INVULN_FRAMES);
               if (lives_q <= 4'd1) begin
                  lives_d = 4'd0;
                  state_d = S_OVER;
               end else begin
                  lives_d = lives_q - 4'd1;
               end
            end
`ifdef GAME_CTRL_PAUSE_EN
            else if (pause_ev) begin
               state_d = S_PAUSE;
            end
`endif
         end
`ifdef GAME_CTRL_PAUSE_EN
         S_PAUSE: begin
            if (pause_ev) state_d = S_PLAY;
         end
`endif
         S_OVER: begin
            if (score_cnt > hiscore_q) hiscore_d = score_cnt;
            if (start_ev) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= S_IDLE;
         fs1_q        <= 1'b0;
         fs2_q        <= 1'b0;
         fs_prev_q    <= 1'b0;
         frame_tick_q <= 1'b0;
         key_prev_q   <= 8'h00;
         lives_q      <= 4'd0;
         speed_q      <= 4'd0;
         inv_cnt_q    <= '0;
         spd_cnt_q    <= '0;
         hiscore_q    <= '0;
         invuln_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         fs1_q        <= frame_clk;
         fs2_q        <= fs1_q;
         fs_prev_q    <= fs2_q;
         frame_tick_q <= fs2_q & ~fs_prev_q;
         key_prev_q   <= keycode;
         lives_q      <= lives_d;
         speed_q      <= speed_d;
         inv_cnt_q    <= inv_cnt_d;
         spd_cnt_q    <= spd_cnt_d;
         hiscore_q    <= hiscore_d;
         invuln_q     <= (inv_cnt_d != '0);
      end
   end

   assign status     = state_q;
   assign score      = score_cnt;
   assign hiscore    = hiscore_q;
   assign lives      = lives_q;
   assign speed      = speed_q;
   assign invuln     = invuln_q;
   assign frame_tick = frame_tick_q;

endmodule
